// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tl_pkg
// Purpose  : shared state codes, lamp bit indices and 7-segment decode for
//            the intersection controller
// Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

    typedef enum logic [3:0] {
        S_IDLE             = 4'd0,
        S_ALL_RED_2        = 4'd1,
        S_MAIN_RED_YELLOW  = 4'd2,
        S_MAIN_GREEN       = 4'd3,
        S_MAIN_GREEN_BLINK = 4'd4,
        S_MAIN_YELLOW      = 4'd5,
        S_ALL_RED_1        = 4'd6,
        S_SIDE_RED_YELLOW  = 4'd7,
        S_SIDE_GREEN       = 4'd8,
        S_SIDE_GREEN_BLINK = 4'd9,
        S_SIDE_YELLOW      = 4'd10,
        S_NIGHT            = 4'd11
    } state_e;

    localparam int c_RED = 0;
    localparam int c_YEL = 1;
    localparam int c_GRN = 2;

    // Segment order is gfedcba; anything above 9 is blanked.
    function automatic logic [6:0] seg7_decode(input logic [31:0] value);
        logic [6:0] pattern;
        case (value)
            32'd0:   pattern = 7'b0111111;
            32'd1:   pattern = 7'b0000110;
            32'd2:   pattern = 7'b1011011;
            32'd3:   pattern = 7'b1001111;
            32'd4:   pattern = 7'b1100110;
            32'd5:   pattern = 7'b1101101;
            32'd6:   pattern = 7'b1111101;
            32'd7:   pattern = 7'b0000111;
            32'd8:   pattern = 7'b1111111;
            32'd9:   pattern = 7'b1101111;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_intersection_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : tl_intersection_ctrl_if
// Purpose   : request inputs and lamp/countdown outputs of the controller
// Revision  : 1.0 - initial release
// ============================================================================
interface tl_intersection_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             ena;
    logic             side_req;
    logic             ped_req;
    logic             night_mode;
    logic [2:0]       main_light;
    logic [2:0]       side_light;
    logic             ped_walk;
    logic             ped_wait;
    logic [CNT_W-1:0] remaining;
    logic [6:0]       seg;
    logic [3:0]       state_out;

    modport master (
        output ena, side_req, ped_req, night_mode,
        input  main_light, side_light, ped_walk, ped_wait, remaining, seg, state_out
    );

    modport slave (
        input  ena, side_req, ped_req, night_mode,
        output main_light, side_light, ped_walk, ped_wait, remaining, seg, state_out
    );
endinterface
`default_nettype wire

// File: rtl/tl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tl_tick_gen
// Purpose  : prescaler producing one timing tick every TICK_DIV enabled cycles
// Revision : 1.0 - initial release
// ============================================================================
module tl_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ena,
    output logic o_tick
);
    localparam int c_DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DW-1:0] c_LAST = c_DW'(TICK_DIV - 1);

    logic [c_DW-1:0] r_div_cnt;

    // Gated by ena so a frozen controller never sees a tick.
    assign o_tick = i_ena && (r_div_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_ena) begin
            r_div_cnt <= o_tick ? '0 : r_div_cnt + c_DW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/tl_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tl_intersection_ctrl
// Purpose  : main/side traffic-light controller with pedestrian phase,
//            demand-extended main green and night blink mode
// Revision : 1.0 - initial release
// ============================================================================
module tl_intersection_ctrl
    import tl_pkg::*;
#(
    parameter int TICK_DIV      = 4,
    parameter int CNT_W         = 4,
    parameter int T_IDLE        = 6,
    parameter int T_MAIN_GREEN  = 9,
    parameter int T_SIDE_GREEN  = 6,
    parameter int T_GREEN_BLINK = 5,
    parameter int T_YELLOW      = 3,
    parameter int T_RED_YELLOW  = 3,
    parameter int T_ALL_RED     = 2,
    parameter int BLINK_DIV     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tl_intersection_ctrl_if.slave bus
);
    localparam int c_T_MAX = (1 << CNT_W) - 1;
    localparam int c_BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);

    if (TICK_DIV < 1 || BLINK_DIV < 1 ||
        T_IDLE < 1 || T_IDLE > c_T_MAX ||
        T_MAIN_GREEN < 1 || T_MAIN_GREEN > c_T_MAX ||
        T_SIDE_GREEN < 1 || T_SIDE_GREEN > c_T_MAX ||
        T_GREEN_BLINK < 1 || T_GREEN_BLINK > c_T_MAX ||
        T_YELLOW < 1 || T_YELLOW > c_T_MAX ||
        T_RED_YELLOW < 1 || T_RED_YELLOW > c_T_MAX ||
        T_ALL_RED < 1 || T_ALL_RED > c_T_MAX) begin : g_param_check
        $error("tl_intersection_ctrl: illegal parameter set");
    end

    logic             w_tick;
    state_e           r_state, w_state_nxt, w_seq_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_phase_len, w_remaining;
    logic [c_BW-1:0]  r_bdiv, w_bdiv_nxt;
    logic             r_blink, w_blink_nxt;
    logic             r_ped_pending, w_ped_pending_nxt;
    logic             r_night_path, w_night_path_nxt;
    logic             w_blink_state, w_demand;
    logic [2:0]       w_main_light, w_side_light;
    logic             w_ped_walk;

    tl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_ena  (bus.ena),
        .o_tick (w_tick)
    );

    assign w_demand      = bus.side_req | r_ped_pending | bus.night_mode;
    assign w_blink_state = (r_state == S_IDLE) || (r_state == S_NIGHT) ||
                           (r_state == S_MAIN_GREEN_BLINK) || (r_state == S_SIDE_GREEN_BLINK);

    always_comb begin
        w_phase_len = '0;
        w_seq_nxt   = r_state;
        case (r_state)
            S_IDLE:             begin w_phase_len = CNT_W'(T_IDLE);        w_seq_nxt = S_ALL_RED_2;        end
            S_ALL_RED_2:        begin w_phase_len = CNT_W'(T_ALL_RED);     w_seq_nxt = S_MAIN_RED_YELLOW;  end
            S_MAIN_RED_YELLOW:  begin w_phase_len = CNT_W'(T_RED_YELLOW);  w_seq_nxt = S_MAIN_GREEN;       end
            S_MAIN_GREEN:       begin w_phase_len = CNT_W'(T_MAIN_GREEN);                                  end
            S_MAIN_GREEN_BLINK: begin w_phase_len = CNT_W'(T_GREEN_BLINK); w_seq_nxt = S_MAIN_YELLOW;      end
            S_MAIN_YELLOW:      begin
                w_phase_len = CNT_W'(T_YELLOW);
                w_seq_nxt   = r_night_path ? S_NIGHT : S_ALL_RED_1;
            end
            S_ALL_RED_1:        begin w_phase_len = CNT_W'(T_ALL_RED);     w_seq_nxt = S_SIDE_RED_YELLOW;  end
            S_SIDE_RED_YELLOW:  begin w_phase_len = CNT_W'(T_RED_YELLOW);  w_seq_nxt = S_SIDE_GREEN;       end
            S_SIDE_GREEN:       begin w_phase_len = CNT_W'(T_SIDE_GREEN);  w_seq_nxt = S_SIDE_GREEN_BLINK; end
            S_SIDE_GREEN_BLINK: begin w_phase_len = CNT_W'(T_GREEN_BLINK); w_seq_nxt = S_SIDE_YELLOW;      end
            S_SIDE_YELLOW:      begin w_phase_len = CNT_W'(T_YELLOW);      w_seq_nxt = S_ALL_RED_2;        end
            default:            begin w_phase_len = '0;                    w_seq_nxt = r_state;            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bdiv        <= '0;
            r_blink       <= 1'b0;
            r_ped_pending <= 1'b0;
            r_night_path  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bdiv        <= w_bdiv_nxt;
            r_blink       <= w_blink_nxt;
            r_ped_pending <= w_ped_pending_nxt;
            r_night_path  <= w_night_path_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_night_path_nxt = r_night_path;
        if (w_tick) begin
            case (r_state)
                // Main green saturates at its full length and waits for demand.
                S_MAIN_GREEN: begin
                    if (r_cnt != w_phase_len) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else if (w_demand) begin
                        w_state_nxt      = S_MAIN_GREEN_BLINK;
                        w_cnt_nxt        = '0;
                        w_night_path_nxt = bus.night_mode;
                    end
                end
                S_NIGHT: begin
                    if (!bus.night_mode) begin
                        w_state_nxt      = S_ALL_RED_2;
                        w_night_path_nxt = 1'b0;
                    end
                end
                default: begin
                    if (r_cnt == w_phase_len - CNT_W'(1)) begin
                        w_state_nxt = w_seq_nxt;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end

        w_blink_nxt = r_blink;
        w_bdiv_nxt  = r_bdiv;
        if (w_state_nxt != r_state) begin
            w_blink_nxt = 1'b0;
            w_bdiv_nxt  = '0;
        end else if (w_tick && w_blink_state) begin
            if (r_bdiv == c_BLINK_LAST) begin
                w_bdiv_nxt  = '0;
                w_blink_nxt = ~r_blink;
            end else begin
                w_bdiv_nxt = r_bdiv + c_BW'(1);
            end
        end

        // Entry into side green serves the request and masks a same-cycle press.
        w_ped_pending_nxt = r_ped_pending;
        if (r_state != S_SIDE_GREEN) begin
            if (w_state_nxt == S_SIDE_GREEN) begin
                w_ped_pending_nxt = 1'b0;
            end else if (bus.ped_req) begin
                w_ped_pending_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        w_main_light = 3'b000;
        w_side_light = 3'b000;
        w_ped_walk   = 1'b0;
        case (r_state)
            S_IDLE, S_NIGHT: begin
                w_main_light[c_YEL] = r_blink;
                w_side_light[c_YEL] = r_blink;
            end
            S_MAIN_RED_YELLOW: begin
                w_main_light[c_RED] = 1'b1;
                w_main_light[c_YEL] = 1'b1;
                w_side_light[c_RED] = 1'b1;
            end
            S_MAIN_GREEN: begin
                w_main_light[c_GRN] = 1'b1;
                w_side_light[c_RED] = 1'b1;
            end
            S_MAIN_GREEN_BLINK: begin
                w_main_light[c_GRN] = r_blink;
                w_side_light[c_RED] = 1'b1;
            end
            S_MAIN_YELLOW: begin
                w_main_light[c_YEL] = 1'b1;
                w_side_light[c_RED] = 1'b1;
            end
            S_ALL_RED_1, S_ALL_RED_2: begin
                w_main_light[c_RED] = 1'b1;
                w_side_light[c_RED] = 1'b1;
            end
            S_SIDE_RED_YELLOW: begin
                w_main_light[c_RED] = 1'b1;
                w_side_light[c_RED] = 1'b1;
                w_side_light[c_YEL] = 1'b1;
            end
            S_SIDE_GREEN: begin
                w_main_light[c_RED] = 1'b1;
                w_side_light[c_GRN] = 1'b1;
                w_ped_walk          = 1'b1;
            end
            S_SIDE_GREEN_BLINK: begin
                w_main_light[c_RED] = 1'b1;
                w_side_light[c_GRN] = r_blink;
                w_ped_walk          = r_blink;
            end
            S_SIDE_YELLOW: begin
                w_main_light[c_RED] = 1'b1;
                w_side_light[c_YEL] = 1'b1;
            end
            default: begin
                w_main_light = 3'b000;
                w_side_light = 3'b000;
            end
        endcase
        w_remaining = (r_state == S_NIGHT) ? '0 : (w_phase_len - r_cnt);
    end

    assign bus.main_light = w_main_light;
    assign bus.side_light = w_side_light;
    assign bus.ped_walk   = w_ped_walk;
    assign bus.ped_wait   = r_ped_pending;
    assign bus.remaining  = w_remaining;
    assign bus.seg        = seg7_decode(32'(w_remaining));
    assign bus.state_out  = r_state;
endmodule
`default_nettype wire

// File: tb/tb_tl_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_intersection_ctrl
// Purpose  : directed + random bench for two controller instances (tick
//            divider 1 and 4) against a phase/elapsed-time reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_intersection_ctrl;
    import tl_pkg::*;

    localparam int CNT_W = 4;
    localparam int T_IDLE = 6, T_MG = 9, T_SG = 6, T_GB = 5, T_Y = 3, T_RY = 3, T_AR = 2;
    localparam int BLINK_DIV = 1;
    localparam int TD_A = 1, TD_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena, side_req, ped_req, night_mode;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    tl_intersection_ctrl_if #(.CNT_W(CNT_W)) bus_a ();
    tl_intersection_ctrl_if #(.CNT_W(CNT_W)) bus_b ();

    assign bus_a.ena = ena;  assign bus_a.side_req = side_req;
    assign bus_a.ped_req = ped_req;  assign bus_a.night_mode = night_mode;
    assign bus_b.ena = ena;  assign bus_b.side_req = side_req;
    assign bus_b.ped_req = ped_req;  assign bus_b.night_mode = night_mode;

    tl_intersection_ctrl #(
        .TICK_DIV(TD_A), .CNT_W(CNT_W), .T_IDLE(T_IDLE), .T_MAIN_GREEN(T_MG),
        .T_SIDE_GREEN(T_SG), .T_GREEN_BLINK(T_GB), .T_YELLOW(T_Y),
        .T_RED_YELLOW(T_RY), .T_ALL_RED(T_AR), .BLINK_DIV(BLINK_DIV)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    tl_intersection_ctrl #(
        .TICK_DIV(TD_B), .CNT_W(CNT_W), .T_IDLE(T_IDLE), .T_MAIN_GREEN(T_MG),
        .T_SIDE_GREEN(T_SG), .T_GREEN_BLINK(T_GB), .T_YELLOW(T_Y),
        .T_RED_YELLOW(T_RY), .T_ALL_RED(T_AR), .BLINK_DIV(BLINK_DIV)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Model: which phase, how many ticks have elapsed in it, prescaler position.
    typedef struct packed {
        int     div;
        int     el;
        state_e ph;
        bit     pend;
        bit     np;
    } model_t;

    model_t ma, mb;

    function automatic model_t mreset();
        model_t m;
        m.div = 0; m.el = 0; m.ph = S_IDLE; m.pend = 1'b0; m.np = 1'b0;
        return m;
    endfunction

    function automatic int tlen(state_e s);
        case (s)
            S_IDLE:                                return T_IDLE;
            S_ALL_RED_1, S_ALL_RED_2:              return T_AR;
            S_MAIN_RED_YELLOW, S_SIDE_RED_YELLOW:  return T_RY;
            S_MAIN_GREEN:                          return T_MG;
            S_SIDE_GREEN:                          return T_SG;
            S_MAIN_GREEN_BLINK, S_SIDE_GREEN_BLINK: return T_GB;
            S_MAIN_YELLOW, S_SIDE_YELLOW:          return T_Y;
            default:                               return 0;
        endcase
    endfunction

    function automatic state_e seq_after(state_e s, bit np);
        case (s)
            S_IDLE:             return S_ALL_RED_2;
            S_ALL_RED_2:        return S_MAIN_RED_YELLOW;
            S_MAIN_RED_YELLOW:  return S_MAIN_GREEN;
            S_MAIN_GREEN_BLINK: return S_MAIN_YELLOW;
            S_MAIN_YELLOW:      return np ? S_NIGHT : S_ALL_RED_1;
            S_ALL_RED_1:        return S_SIDE_RED_YELLOW;
            S_SIDE_RED_YELLOW:  return S_SIDE_GREEN;
            S_SIDE_GREEN:       return S_SIDE_GREEN_BLINK;
            S_SIDE_GREEN_BLINK: return S_SIDE_YELLOW;
            S_SIDE_YELLOW:      return S_ALL_RED_2;
            default:            return s;
        endcase
    endfunction

    function automatic model_t mstep(model_t m, int tdiv, logic en, logic sr, logic pr, logic nm);
        model_t n;
        bit     tick;
        n    = m;
        tick = en && (m.div == tdiv - 1);
        if (en) n.div = (m.div + 1) % tdiv;
        if (tick) begin
            if (m.ph == S_MAIN_GREEN) begin
                if (m.el >= T_MG && (sr || m.pend || nm)) begin
                    n.ph = S_MAIN_GREEN_BLINK; n.el = 0; n.np = nm;
                end else n.el = m.el + 1;
            end else if (m.ph == S_NIGHT) begin
                if (!nm) begin n.ph = S_ALL_RED_2; n.el = 0; n.np = 1'b0; end
                else n.el = m.el + 1;
            end else if (m.el + 1 >= tlen(m.ph)) begin
                n.ph = seq_after(m.ph, m.np); n.el = 0;
            end else n.el = m.el + 1;
        end
        if (n.ph == S_SIDE_GREEN && m.ph != S_SIDE_GREEN) n.pend = 1'b0;
        else if (pr && m.ph != S_SIDE_GREEN)               n.pend = 1'b1;
        return n;
    endfunction

    function automatic logic [6:0] seg_ref(int v);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (v >= 0 && v <= 9) ? tab[v] : 7'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_dut(input string who, input model_t m,
                             input logic [2:0] ml, input logic [2:0] sl,
                             input logic pw, input logic pwt,
                             input logic [CNT_W-1:0] rem, input logic [6:0] sg,
                             input logic [3:0] st);
        logic [2:0] em, es;
        logic       ew, bl;
        int         er;
        bl = 1'b0;
        if (m.ph == S_IDLE || m.ph == S_NIGHT || m.ph == S_MAIN_GREEN_BLINK || m.ph == S_SIDE_GREEN_BLINK)
            bl = ((m.el / BLINK_DIV) % 2) == 1;
        em = 3'b000; es = 3'b000; ew = 1'b0;
        case (m.ph)
            S_IDLE, S_NIGHT:          begin em = bl ? 3'b010 : 3'b000; es = em; end
            S_MAIN_RED_YELLOW:        begin em = 3'b011; es = 3'b001; end
            S_MAIN_GREEN:             begin em = 3'b100; es = 3'b001; end
            S_MAIN_GREEN_BLINK:       begin em = bl ? 3'b100 : 3'b000; es = 3'b001; end
            S_MAIN_YELLOW:            begin em = 3'b010; es = 3'b001; end
            S_ALL_RED_1, S_ALL_RED_2: begin em = 3'b001; es = 3'b001; end
            S_SIDE_RED_YELLOW:        begin em = 3'b001; es = 3'b011; end
            S_SIDE_GREEN:             begin em = 3'b001; es = 3'b100; ew = 1'b1; end
            S_SIDE_GREEN_BLINK:       begin em = 3'b001; es = bl ? 3'b100 : 3'b000; ew = bl; end
            S_SIDE_YELLOW:            begin em = 3'b001; es = 3'b010; end
            default:                  begin em = 3'b000; es = 3'b000; end
        endcase
        er = (m.ph == S_NIGHT) ? 0 : ((tlen(m.ph) > m.el) ? tlen(m.ph) - m.el : 0);
        chk({who, "_main_light"}, 32'(ml), 32'(em));
        chk({who, "_side_light"}, 32'(sl), 32'(es));
        chk({who, "_ped_walk"},   32'(pw), 32'(ew));
        chk({who, "_ped_wait"},   32'(pwt), 32'(m.pend));
        chk({who, "_remaining"},  32'(rem), 32'(er));
        chk({who, "_seg"},        32'(sg), 32'(seg_ref(er)));
        chk({who, "_state"},      32'(st), 32'(m.ph));
    endtask

    task automatic cyc();
        @(posedge clk);
        ma = mstep(ma, TD_A, ena, side_req, ped_req, night_mode);
        mb = mstep(mb, TD_B, ena, side_req, ped_req, night_mode);
        #1;
        check_dut("a", ma, bus_a.main_light, bus_a.side_light, bus_a.ped_walk, bus_a.ped_wait,
                  bus_a.remaining, bus_a.seg, bus_a.state_out);
        check_dut("b", mb, bus_b.main_light, bus_b.side_light, bus_b.ped_walk, bus_b.ped_wait,
                  bus_b.remaining, bus_b.seg, bus_b.state_out);
    endtask

    task automatic run_until(input bit sel_b, input state_e s, input int bound);
        int k;
        k = 0;
        while (((sel_b ? mb.ph : ma.ph) != s) && k < bound) begin
            cyc();
            k++;
        end
        chk(sel_b ? "reach_b" : "reach_a", 32'(sel_b ? bus_b.state_out : bus_a.state_out), 32'(s));
    endtask

    task automatic chk_reset();
        chk("rst_a_main", 32'(bus_a.main_light), 0);  chk("rst_b_main", 32'(bus_b.main_light), 0);
        chk("rst_a_side", 32'(bus_a.side_light), 0);  chk("rst_b_side", 32'(bus_b.side_light), 0);
        chk("rst_a_walk", 32'(bus_a.ped_walk), 0);    chk("rst_b_walk", 32'(bus_b.ped_walk), 0);
        chk("rst_a_wait", 32'(bus_a.ped_wait), 0);    chk("rst_b_wait", 32'(bus_b.ped_wait), 0);
        chk("rst_a_rem", 32'(bus_a.remaining), 6);    chk("rst_b_rem", 32'(bus_b.remaining), 6);
        chk("rst_a_seg", 32'(bus_a.seg), 32'b1111101); chk("rst_b_seg", 32'(bus_b.seg), 32'b1111101);
        chk("rst_a_state", 32'(bus_a.state_out), 32'(S_IDLE));
        chk("rst_b_state", 32'(bus_b.state_out), 32'(S_IDLE));
    endtask

    initial begin
        ena = 1'b1; side_req = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
        ma = mreset(); mb = mreset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // Startup blink, then into main green and hold without demand.
        run_until(1'b0, S_MAIN_GREEN, 40);
        repeat (60) cyc();

        // Side demand, pedestrian press during main yellow.
        side_req = 1'b1; cyc(); side_req = 1'b0;
        run_until(1'b0, S_MAIN_YELLOW, 40);
        ped_req = 1'b1; cyc(); ped_req = 1'b0;
        run_until(1'b0, S_SIDE_GREEN, 40);
        run_until(1'b0, S_SIDE_YELLOW, 40);
        run_until(1'b0, S_MAIN_GREEN, 40);
        repeat (12) cyc();

        // Night and side demand together: night wins.
        side_req = 1'b1; night_mode = 1'b1;
        run_until(1'b0, S_NIGHT, 40);
        repeat (10) cyc();
        side_req = 1'b0; night_mode = 1'b0;
        run_until(1'b0, S_MAIN_GREEN, 40);

        // Enable stall in the middle of side green on the divided instance.
        side_req = 1'b1;
        run_until(1'b1, S_SIDE_GREEN, 600);
        side_req = 1'b0;
        repeat (5) cyc();
        ena = 1'b0; repeat (10) cyc(); ena = 1'b1;
        run_until(1'b1, S_SIDE_YELLOW, 200);

        // Asynchronous reset between clock edges.
        #3; rst = 1'b1; #1;
        chk_reset();
        ma = mreset(); mb = mreset();
        @(posedge clk); #1; rst = 1'b0;
        run_until(1'b0, S_ALL_RED_2, 20);

        repeat (3000) begin
            side_req = (($urandom % 8) == 0);
            ped_req  = (($urandom % 16) == 0);
            if (($urandom % 50) == 0) night_mode = ~night_mode;
            ena      = (($urandom % 8) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tl_intersection_ctrl.md
Name: tl_intersection_ctrl

Overview:
Parametrised two-approach (main road / side road) traffic-light controller with pedestrian crossing, demand-driven main-green extension and a night blink mode. It generalises the single-light sequencer: phase times and tick rate are parameters, and a prescaler derives a timing tick from clk. It sits directly behind the TT pin wrapper, driving lamp outputs plus a 7-segment countdown of the current phase.

Parameters:
TICK_DIV, 4, clk cycles per timing tick (>=1)
CNT_W, 4, width of phase counter and remaining output; must hold every T_* value
T_IDLE, 6, startup blink phase length in ticks
T_MAIN_GREEN, 9, minimum main-green time in ticks
T_SIDE_GREEN, 6, side-green (pedestrian walk) time in ticks
T_GREEN_BLINK, 5, green-blink time in ticks, both approaches
T_YELLOW, 3, yellow time in ticks
T_RED_YELLOW, 3, red+yellow time in ticks
T_ALL_RED, 2, all-red clearance time in ticks
BLINK_DIV, 1, ticks per blink toggle

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ena  in  1  1 = run; 0 = freeze prescaler, counters and state; request inputs are still latched
side_req  in  1  side-road vehicle sensor, level
ped_req  in  1  pedestrian button, level or pulse
night_mode  in  1  1 = request night blink mode
main_light  out  3  main lamps: bit0 red, bit1 yellow, bit2 green
side_light  out  3  side lamps, same encoding
ped_walk  out  1  pedestrian walk lamp
ped_wait  out  1  pedestrian request pending indicator
remaining  out  CNT_W  ticks left in the current timed phase
seg  out  7  7-segment pattern of remaining (gfedcba); blank if remaining > 9
state_out  out  4  current state code, for debug

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high. All outputs are Moore, decoded from registered state.
- Prescaler: div_cnt counts 0..TICK_DIV-1 while ena=1. tick=1 in the cycle div_cnt==TICK_DIV-1. The first tick occurs TICK_DIV cycles after rst deasserts.
- Phase counter cnt advances only on tick. A timed phase of length T lasts exactly T ticks: on the tick where cnt==T-1, the state changes and cnt is cleared to 0. remaining = T - cnt.
- State sequence: IDLE(T_IDLE) -> ALL_RED_2 -> MAIN_RED_YELLOW -> MAIN_GREEN -> MAIN_GREEN_BLINK -> MAIN_YELLOW -> ALL_RED_1 -> SIDE_RED_YELLOW -> SIDE_GREEN -> SIDE_GREEN_BLINK -> SIDE_YELLOW -> ALL_RED_2 -> ...
- MAIN_GREEN extension: after T_MAIN_GREEN ticks, MAIN_GREEN holds with cnt saturated and remaining=0. It leaves on the next tick where side_req=1, ped_pending=1 or night_mode=1.
- Night priority: if night_mode=1 at MAIN_GREEN exit, the night_path flag is set. MAIN_YELLOW then goes to NIGHT instead of ALL_RED_1.
- NIGHT: untimed, remaining=0. Exits to ALL_RED_2 on the first tick with night_mode=0, and clears night_path. night_mode is ignored in all other states.
- ped_pending: set on any cycle with ped_req=1, except in SIDE_GREEN; cleared on entry to SIDE_GREEN. ped_wait = ped_pending.
- Lamps by state (non-listed lamps off):
  - MAIN_GREEN: main G, side R.
  - MAIN_GREEN_BLINK: main G=blink, side R.
  - MAIN_YELLOW: main Y, side R.
  - ALL_RED_1 and ALL_RED_2: both R.
  - SIDE_RED_YELLOW: side R+Y, main R.
  - SIDE_GREEN: side G, main R, ped_walk=1.
  - SIDE_GREEN_BLINK: side G=blink, ped_walk=blink, main R.
  - SIDE_YELLOW: side Y, main R.
  - MAIN_RED_YELLOW: main R+Y, side R.
  - IDLE and NIGHT: main Y = side Y = blink; all other lamps off.
- Blink: the blink register is cleared on every state change and toggles every BLINK_DIV ticks in blink states, so each blink state starts with the lamp off. It is 0 in all other states.
- Reset (also mid-operation): state=IDLE, cnt=0, div_cnt=0, blink=0, ped_pending=0, night_path=0. Outputs at reset: lights 000/000, ped_walk=0, ped_wait=0, remaining=T_IDLE, seg=decode(T_IDLE), state_out=IDLE.
- Simultaneous events:
  - ped_req in the cycle of SIDE_GREEN entry: ignored.
  - side_req and night_mode both high at MAIN_GREEN exit: night wins; ped_pending is retained.
- Widths: remaining is CNT_W bits and never negative. Parameters are checked at elaboration: every T_* >= 1 and < 2**CNT_W.

Decomposition:
- Package tl_pkg: state enum (4-bit codes), lamp bit-index constants (RED=0, YEL=1, GRN=2), and a 7-segment decode function (0-9, else blank).
- Sub-module tl_tick_gen: prescaler with TICK_DIV parameter, inputs ena, output tick.

Test Plan:
- TICK_DIV=1, defaults, release rst: exactly 6 ticks of IDLE with yellow blinking 0,1,0,1,0,1. Then 2 ticks all-red, 3 ticks main R+Y, then MAIN_GREEN with remaining counting 9..1 then 0.
- Hold all requests low for 50 cycles in MAIN_GREEN: main_light=100 (green) held. Pulse side_req: 5 blink ticks, 3 yellow, 2 all-red, 3 side R+Y, then side_light=100 (green) for 6 ticks.
- Pulse ped_req for 1 cycle during MAIN_YELLOW: ped_wait=1 until SIDE_GREEN entry. ped_walk=1 for 6 ticks, then blinks for 5 ticks, then 0.
- night_mode=1 in MAIN_GREEN hold, with side_req=1 as well: blink, then yellow, then NIGHT with both yellows blinking. Drop night_mode: 2 all-red ticks, main R+Y, main green.
- TICK_DIV=4: ena=0 for 10 cycles mid-SIDE_GREEN holds state, remaining and div_cnt unchanged. The phase ends 10 cycles later than it would without the stall.
- Assert rst asynchronously mid-SIDE_YELLOW (between clk edges): outputs go immediately to the reset values (remaining=6, seg=1111101), and the IDLE sequence restarts on release.
